// File: rtl/lbdr_pkg.sv
// Shared types and constants for the LBDR routing unit.
// Flit codes, FSM states and one-hot port indices.
package lbdr_pkg;

  localparam logic [2:0] HEADER      = 3'b001;
  localparam logic [2:0] PAYLOAD     = 3'b010;
  localparam logic [2:0] TAIL        = 3'b100;
  localparam logic [2:0] HEADER_TAIL = 3'b101;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int P_N   = 0;
  localparam int P_E   = 1;
  localparam int P_W   = 2;
  localparam int P_S   = 3;
  localparam int P_L   = 4;
  localparam int NPORT = 5;

  // Keep the lowest set bit: N > E > W > S.
  function automatic logic [3:0] pick4(
    input logic [3:0] v
  );
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/lbdr_dr_if.sv
// FIFO-side, config and port-request signals of one LBDR input port.
// The router is the slave, the FIFO/allocator side is the master.
interface lbdr_dr_if #(
  parameter int AW = 4
);
  logic          empty;
  logic          rd_en;
  logic [2:0]    flit_id;
  logic [AW-1:0] dst_addr;
  logic          cfg_we;
  logic [7:0]    cfg_rxy;
  logic [3:0]    cfg_cx;
  logic [3:0]    cfg_dr;
  logic [AW-1:0] cfg_cur;
  logic          Nport;
  logic          Eport;
  logic          Wport;
  logic          Sport;
  logic          Lport;
  logic          busy;
  logic          err;

  modport master (
    output empty, rd_en, flit_id, dst_addr,
    output cfg_we, cfg_rxy, cfg_cx,
    output cfg_dr, cfg_cur,
    input  Nport, Eport, Wport, Sport,
    input  Lport, busy, err
  );

  modport slave (
    input  empty, rd_en, flit_id, dst_addr,
    input  cfg_we, cfg_rxy, cfg_cx,
    input  cfg_dr, cfg_cur,
    output Nport, Eport, Wport, Sport,
    output Lport, busy, err
  );
endinterface

// File: rtl/lbdr_route_comb.sv
// Combinational LBDR route: minimal ports, then deroute fallback.
// Result is one-hot {L,S,W,E,N}; fail flags an unroutable header.
module lbdr_route_comb
  import lbdr_pkg::*;
#(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  logic [X_W+Y_W-1:0] cur,
  input  logic [X_W+Y_W-1:0] dst,
  input  logic [7:0]         rxy,
  input  logic [3:0]         cx,
  input  logic [3:0]         dr,
  output logic [NPORT-1:0]   port,
  output logic               fail
);

  logic [X_W-1:0] xc, xd;
  logic [Y_W-1:0] yc, yd;
  logic n1, s1, e1, w1;
  logic mn, me, mw, ms, loc;
  logic [3:0] mins, der;

  assign xc = cur[X_W-1:0];
  assign xd = dst[X_W-1:0];
  assign yc = cur[X_W+Y_W-1:X_W];
  assign yd = dst[X_W+Y_W-1:X_W];

  assign n1 = yd < yc;
  assign s1 = yc < yd;
  assign e1 = xc < xd;
  assign w1 = xd < xc;

  // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
  assign mn = (n1 & ~e1 & ~w1
            | n1 & e1 & rxy[0]
            | n1 & w1 & rxy[1]) & cx[0];
  assign me = (e1 & ~n1 & ~s1
            | e1 & n1 & rxy[2]
            | e1 & s1 & rxy[3]) & cx[1];
  assign mw = (w1 & ~n1 & ~s1
            | w1 & n1 & rxy[4]
            | w1 & s1 & rxy[5]) & cx[2];
  assign ms = (s1 & ~e1 & ~w1
            | s1 & e1 & rxy[6]
            | s1 & w1 & rxy[7]) & cx[3];
  assign loc = ~n1 & ~e1 & ~w1 & ~s1;

  assign mins = {ms, mw, me, mn};
  assign der  = dr & cx;

  always_comb begin
    port = '0;
    fail = 1'b0;
    if (loc)
      port[P_L] = 1'b1;
    else if (|mins)
      port[3:0] = pick4(mins);
    else if (|der)
      port[3:0] = pick4(der);
    else
      fail = 1'b1;
  end

endmodule

// File: rtl/lbdr_dr.sv
// LBDR input-port router with deroutes, packet lock and
// run-time reconfiguration; registered one-hot port request.
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int                 X_W     = 2,
  parameter int                 Y_W     = 2,
  parameter logic [7:0]         RXY_DEF = 8'd60,
  parameter logic [3:0]         CX_DEF  = 4'd15,
  parameter logic [3:0]         DR_DEF  = 4'd0,
  parameter logic [X_W+Y_W-1:0] CUR_DEF = 'd5
) (
  input logic     clk,
  input logic     rst,
  lbdr_dr_if.slave bus
);

  localparam int AW = X_W + Y_W;

  state_t state_q, state_d;

  logic [7:0]       rxy_q;
  logic [3:0]       cx_q, dr_q;
  logic [AW-1:0]    cur_q;
  logic [NPORT-1:0] port_q, port_d, route;
  logic fail;
  logic err_q, err_d;
  logic pend_q, pend_d;
  logic ht_q, ht_d;
  logic cfg_ld;
  logic is_hdr, is_tail, rel;

  lbdr_route_comb #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_route (
    .cur  (cur_q),
    .dst  (bus.dst_addr),
    .rxy  (rxy_q),
    .cx   (cx_q),
    .dr   (dr_q),
    .port (route),
    .fail (fail)
  );

  assign is_hdr = bus.flit_id == HEADER
               || bus.flit_id == HEADER_TAIL;
  assign is_tail = bus.flit_id == TAIL;

  // pend_q: the locked header is still at the FIFO head.
  assign rel = !bus.empty && bus.rd_en
            && (is_tail
             || (bus.flit_id == HEADER_TAIL
                 && ht_q && pend_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!bus.empty && is_hdr && !fail)
          state_d = BUSY;
      BUSY:
        if (rel)
          state_d = IDLE;
    endcase
  end

  always_comb begin
    port_d = port_q;
    err_d  = err_q;
    pend_d = pend_q;
    ht_d   = ht_q;
    cfg_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ld = bus.cfg_we;
        if (!bus.empty) begin
          if (is_hdr && fail) begin
            err_d = 1'b1;
          end else if (is_hdr) begin
            port_d = route;
            pend_d = 1'b1;
            ht_d   = bus.flit_id == HEADER_TAIL;
          end else if (bus.flit_id == PAYLOAD
                    || is_tail) begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.cfg_we)
          err_d = 1'b1;
        if (rel) begin
          port_d = '0;
          pend_d = 1'b0;
          ht_d   = 1'b0;
        end else if (!bus.empty) begin
          if (pend_q && bus.rd_en)
            pend_d = 1'b0;
          else if (is_hdr && !pend_q)
            err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q <= '0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      ht_q   <= 1'b0;
      rxy_q  <= RXY_DEF;
      cx_q   <= CX_DEF;
      dr_q   <= DR_DEF;
      cur_q  <= CUR_DEF;
    end else begin
      port_q <= port_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      ht_q   <= ht_d;
      if (cfg_ld) begin
        rxy_q <= bus.cfg_rxy;
        cx_q  <= bus.cfg_cx;
        dr_q  <= bus.cfg_dr;
        cur_q <= bus.cfg_cur;
      end
    end
  end

  assign bus.Nport = port_q[P_N];
  assign bus.Eport = port_q[P_E];
  assign bus.Wport = port_q[P_W];
  assign bus.Sport = port_q[P_S];
  assign bus.Lport = port_q[P_L];
  assign bus.busy  = state_q == BUSY;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_lbdr_dr.sv
// Directed bench for lbdr_dr: X_W=Y_W=2, cur=5, default config.
// Ports are observed as {L,S,W,E,N}, sampled 1ns after each edge.
module tb_lbdr_dr;
  import lbdr_pkg::*;

  localparam logic [4:0] PL = 5'b10000;
  localparam logic [4:0] PS = 5'b01000;
  localparam logic [4:0] PE = 5'b00010;
  localparam logic [4:0] PN = 5'b00001;
  localparam logic [4:0] P0 = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] pv;

  lbdr_dr_if #(.AW(4)) bus ();

  lbdr_dr #(
    .X_W (2),
    .Y_W (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign pv = {bus.Lport, bus.Sport, bus.Wport,
               bus.Eport, bus.Nport};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic r,
                     input logic [2:0] id,
                     input logic [3:0] d);
    bus.empty    = e;
    bus.rd_en    = r;
    bus.flit_id  = id;
    bus.dst_addr = d;
  endtask

  task automatic idle();
    drv(1'b1, 1'b0, PAYLOAD, 4'd0);
  endtask

  task automatic cfg(input logic [7:0] rxy,
                     input logic [3:0] cx,
                     input logic [3:0] dr);
    idle();
    bus.cfg_rxy = rxy;
    bus.cfg_cx  = cx;
    bus.cfg_dr  = dr;
    bus.cfg_we  = 1'b1;
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  // Route, consume header, consume tail, expect release.
  task automatic send(input logic [3:0] dst,
                      input logic [4:0] exp,
                      input string tag);
    drv(1'b0, 1'b0, HEADER, dst);
    tick();
    chk(tag, pv, exp);
    drv(1'b0, 1'b1, HEADER, dst);
    tick();
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();
    chk({tag, "_rel"}, {pv, bus.busy}, 6'd0);
    idle();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    chk("rst_async", {pv, bus.busy, bus.err}, 7'd0);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    bus.cfg_we  = 1'b0;
    bus.cfg_rxy = 8'h3C;
    bus.cfg_cx  = 4'hF;
    bus.cfg_dr  = 4'h0;
    bus.cfg_cur = 4'd5;
    #2;
    chk("rst_state", {pv, bus.busy, bus.err}, 7'd0);
    tick();
    rst = 1'b0;
    tick();

    drv(1'b0, 1'b0, HEADER, 4'd5);
    tick();
    chk("loc_port", pv, PL);
    chk("loc_busy", bus.busy, 1);
    drv(1'b0, 1'b1, HEADER, 4'd5);
    tick();
    chk("loc_hold", pv, PL);
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();
    chk("loc_rel", {pv, bus.busy}, 6'd0);
    idle();

    send(4'd15, PE, "se_res");
    cfg(8'h40, 4'hF, 4'h0);
    send(4'd15, PS, "se_rse");

    bus.cfg_rxy = 8'h3C;
    bus.cfg_we  = 1'b1;
    drv(1'b0, 1'b0, HEADER, 4'd15);
    tick();
    bus.cfg_we  = 1'b0;
    chk("cfg_old", pv, PS);
    drv(1'b0, 1'b1, HEADER, 4'd15);
    tick();
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();
    idle();
    send(4'd15, PE, "cfg_new");

    cfg(8'h3C, 4'b1101, 4'b0001);
    send(4'd7, PN, "dr_n");
    cfg(8'h3C, 4'b1101, 4'b0000);
    drv(1'b0, 1'b0, HEADER, 4'd7);
    tick();
    chk("fail_port", pv, P0);
    chk("fail_busy", bus.busy, 0);
    chk("fail_err", bus.err, 1);
    idle();
    pulse_rst();
    tick();
    send(4'd7, PE, "dflt_cx");

    drv(1'b0, 1'b0, HEADER, 4'd15);
    tick();
    chk("pk_hdr", pv, PE);
    drv(1'b0, 1'b1, HEADER, 4'd15);
    tick();
    chk("pk_hdr_rd", pv, PE);
    drv(1'b0, 1'b0, PAYLOAD, 4'd0);
    tick();
    chk("pk_pay0", pv, PE);
    drv(1'b0, 1'b1, PAYLOAD, 4'd0);
    tick();
    chk("pk_pay1", pv, PE);
    drv(1'b1, 1'b0, PAYLOAD, 4'd0);
    tick();
    chk("pk_empty", pv, PE);
    drv(1'b0, 1'b0, TAIL, 4'd0);
    tick();
    chk("pk_tail_wait", {pv, bus.busy}, {PE, 1'b1});
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();
    chk("pk_rel", {pv, bus.busy}, 6'd0);
    drv(1'b0, 1'b0, HEADER, 4'd5);
    tick();
    chk("b2b_port", pv, PL);
    chk("b2b_err", bus.err, 0);
    drv(1'b0, 1'b1, HEADER, 4'd5);
    tick();
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();

    drv(1'b0, 1'b0, HEADER_TAIL, 4'd15);
    tick();
    chk("ht_port", pv, PE);
    tick();
    chk("ht_hold", pv, PE);
    drv(1'b0, 1'b1, HEADER_TAIL, 4'd15);
    tick();
    chk("ht_rel", {pv, bus.busy}, 6'd0);
    idle();
    tick();
    chk("ht_err", bus.err, 0);

    drv(1'b0, 1'b0, PAYLOAD, 4'd0);
    tick();
    chk("pay_idle", {pv, bus.busy, bus.err}, 7'd1);
    idle();
    pulse_rst();
    tick();

    cfg(8'h3C, 4'b1101, 4'b0001);
    drv(1'b0, 1'b0, HEADER, 4'd7);
    tick();
    chk("hb_port", pv, PN);
    drv(1'b0, 1'b1, HEADER, 4'd7);
    tick();
    drv(1'b0, 1'b0, HEADER, 4'd5);
    tick();
    chk("hb_held", pv, PN);
    chk("hb_err", bus.err, 1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst", {pv, bus.busy}, 6'd0);
    rst = 1'b0;
    tick();
    send(4'd7, PE, "rst_cfg");

    drv(1'b0, 1'b0, HEADER, 4'd5);
    tick();
    chk("cb_port", pv, PL);
    bus.cfg_cx = 4'h0;
    bus.cfg_we = 1'b1;
    idle();
    tick();
    bus.cfg_we = 1'b0;
    chk("cb_err", {pv, bus.err}, {PL, 1'b1});
    drv(1'b0, 1'b1, HEADER, 4'd5);
    tick();
    drv(1'b0, 1'b1, TAIL, 4'd0);
    tick();
    idle();
    send(4'd15, PE, "cb_ign");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
